rgb565_frame_sequencer: RTL and testbench
=========================================

// Module: rgb565_frame_sequencer
// PURPOSE
//  Frame-level controller for the RGB888->RGB565 pixel path. Locks onto SOF and
//  counts pixels/lines against the configured geometry. Converts 24-bit pixels to
//  RGB565 and packs two per 32-bit AXI-Stream word, regenerating SOF/EOL.
//  Reports status and frame-done pulses. Sits between the video source and the
//  VDMA write channel; cfg_*/sts_* connect to the AXI4-Lite register block.
// PARAMETERS
//  W_BITS    11  width of cfg_width / x counter (max 2046 px/line)
//  H_BITS    11  width of cfg_height / y counter
//  FCNT_BITS 16  width of sts_frame_cnt
// PORTS
//  ACLK            in   1          single clock
//  ARESETN         in   1          asynchronous, active-low reset
//  cfg_enable      in   1          level; 1 = run / re-arm after each frame
//  cfg_oneshot     in   1          1 = return to IDLE after one frame
//  cfg_width       in   W_BITS     pixels per line; LSB ignored (forced even)
//  cfg_height      in   H_BITS     lines per frame
//  s_axis_tdata    in   24         {R[23:16],G[15:8],B[7:0]}
//  s_axis_tvalid   in   1
//  s_axis_tready   out  1
//  s_axis_tuser    in   1          SOF
//  s_axis_tlast    in   1          EOL
//  m_axis_tdata    out  32         {pix1_565, pix0_565}; pix0 = earlier pixel
//  m_axis_tvalid   out  1
//  m_axis_tready   in   1
//  m_axis_tuser    out  1          first word of frame
//  m_axis_tlast    out  1          last word of line
//  sts_busy        out  1          state != IDLE
//  sts_err         out  1          sticky sync/config error; cleared only by reset
//  sts_frame_cnt   out  FCNT_BITS  completed frames, wraps to 0
//  irq_frame_done  out  1          one-cycle pulse per completed frame
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, x=y=0, half-pixel register empty.
//  Beat accepted = s_tvalid & s_tready; word sent = m_tvalid & m_tready.
//  FSM: IDLE, WAIT_SOF, ACTIVE.
//  IDLE: s_tready=0. On cfg_enable=1, latch width (LSB cleared) and height.
//   If width<2 or height==0: set sts_err, stay IDLE. Otherwise go to WAIT_SOF.
//  WAIT_SOF: s_tready=1. Beats with tuser=0 are discarded.
//   A beat with tuser=1 is pixel (0,0) -> ACTIVE.
//  ACTIVE: x counts 0..W-1, then wraps to 0 with y++.
//   Even x: pixel stored in half register; always acceptable.
//   Odd x: needs the output slot, so s_tready = !m_tvalid | m_tready.
//   When the word is formed: m_tvalid=1 next cycle, tuser=(x==1 & y==0),
//   tlast=(x==W-1). Output holds stable until accepted.
//   Latency: odd pixel accepted at cycle N -> word valid at N+1.
//   Sustained: 1 pixel/cycle in, 1 word per 2 cycles out.
//   Last pixel (x=W-1, y=H-1): sts_frame_cnt++ and irq pulse in the same cycle
//   the final word is loaded. Next state is WAIT_SOF if cfg_enable & !cfg_oneshot,
//   else IDLE.
//  Sync errors (ACTIVE), all set sts_err:
//   - tuser=1 with (x,y)!=(0,0): pending half dropped, beat taken as new (0,0),
//     frame restarts, frame_cnt not incremented.
//   - tlast=1 with x!=W-1, or tlast=0 with x==W-1: flagged only; counting
//     follows cfg geometry.
//  cfg_enable=0 mid-frame: frame completes normally, then IDLE.
//   cfg_width/height changes take effect only at the next IDLE latch.
//  Words not yet accepted when going IDLE are still drained (m_tvalid holds).
//  Async reset mid-frame: immediate return to reset state; partial frame lost.
//  Conversion (default, truncate): r5=R[7:3], g6=G[7:2], b5=B[7:3];
//   pix565 = {r5,g6,b5}.
// CONFIGURATION
//  RGB565_ROUND_EN defined: round to nearest with saturation:
//   r5=min((R+4)>>3,31), g6=min((G+2)>>2,63), b5=min((B+4)>>3,31).
//   Adds one register stage: latency odd-pixel -> word becomes 2 cycles.
//   Throughput unchanged.
//  Undefined: truncation, latency 1.
// TESTING
//  1 W=4,H=2, tready=1, 8 beats of 0xFF8040 with SOF on beat0 and tlast on beats 3,7
//    -> 4 words 0xFC08FC08; tuser only on word0; tlast on words 1,3;
//    frame_cnt=1; irq high for exactly 1 cycle.
//  2 As 1 but m_tready=0 for 10 cycles after word0 -> s_tready drops on the next odd
//    pixel; no word lost or duplicated; data matches the order of test 1.
//  3 WAIT_SOF: 3 beats with tuser=0, then a valid frame -> the 3 beats are dropped;
//    first output word carries tuser; sts_err stays 0.
//  4 W=4,H=2, tuser=1 on beat 5 -> sts_err=1; frame restarts at beat 5;
//    frame_cnt increments only after 8 further pixels.
//  5 cfg_oneshot=1, cfg_enable held 1 -> exactly one frame processed;
//    sts_busy=0 afterwards; a following SOF beat is not accepted (s_tready=0).
//  6 Pixel 0x0F0F0F -> pix565 0x0861 without RGB565_ROUND_EN, 0x1082 with it;
//    0xFFFFFF -> 0xFFFF in both builds.

Source files
------------

// File: rtl/rgb565_frame_sequencer.sv
// RGB888 -> RGB565 frame sequencer: SOF lock, geometry counting, two pixels per 32-bit word.
// Build option RGB565_ROUND_EN: round-to-nearest with saturation plus one extra output stage.
module rgb565_frame_sequencer #(
   parameter int W_BITS    = 11,
   parameter int H_BITS    = 11,
   parameter int FCNT_BITS = 16
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic                 cfg_enable,
   input  logic                 cfg_oneshot,
   input  logic [W_BITS-1:0]    cfg_width,
   input  logic [H_BITS-1:0]    cfg_height,
   input  logic [23:0]          s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tuser,
   input  logic                 s_axis_tlast,
   output logic [31:0]          m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tuser,
   output logic                 m_axis_tlast,
   output logic                 sts_busy,
   output logic                 sts_err,
   output logic [FCNT_BITS-1:0] sts_frame_cnt,
   output logic                 irq_frame_done
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, ACTIVE = 2'd2} state_t;

   function automatic logic [15:0] to_565(input logic [23:0] p);
`ifdef RGB565_ROUND_EN
      logic [8:0] r, g, b;
      logic [4:0] r5, b5;
      logic [5:0] g6;
      r  = {1'b0, p[23:16]} + 9'd4;
      g  = {1'b0, p[15:8]}  + 9'd2;
      b  = {1'b0, p[7:0]}   + 9'd4;
      r5 = r[8] ? 5'd31 : r[7:3];
      g6 = g[8] ? 6'd63 : g[7:2];
      b5 = b[8] ? 5'd31 : b[7:3];
      return {r5, g6, b5};
`else
      return {p[23:19], p[15:10], p[7:3]};
`endif
   endfunction

   state_t             state;
   logic [W_BITS-1:0]  width, x;
   logic [H_BITS-1:0]  height, y;
   logic [15:0]        half;
   logic               oneshot_done;
   logic               slot_free, s_ready, accept;
   logic               x_last, y_last, sof_err, word_form;
   logic [W_BITS-1:0]  cfg_width_even;
   logic [15:0]        pix_565;

`ifdef RGB565_ROUND_EN
   logic [31:0]        stg_data;
   logic               stg_valid, stg_user, stg_last, stg_move;
   assign stg_move  = stg_valid & (~m_axis_tvalid | m_axis_tready);
   assign slot_free = ~stg_valid | ~m_axis_tvalid | m_axis_tready;
`else
   assign slot_free = ~m_axis_tvalid | m_axis_tready;
`endif

   assign cfg_width_even = cfg_width & ~W_BITS'(1);
   assign pix_565        = to_565(s_axis_tdata);
   assign accept         = s_axis_tvalid & s_ready;
   assign x_last         = (x == width - W_BITS'(1));
   assign y_last         = (y == height - H_BITS'(1));
   assign sof_err        = accept & (state == ACTIVE) & s_axis_tuser &
                           ((x != {W_BITS{1'b0}}) | (y != {H_BITS{1'b0}}));
   assign word_form      = accept & (state == ACTIVE) & ~sof_err & x[0];
   assign s_axis_tready  = s_ready;
   assign sts_busy       = (state != IDLE);

   // Input readiness: odd pixels complete a word and need a free output slot.
   always_comb begin
      s_ready = 1'b0;
      case (state)
         IDLE:     s_ready = 1'b0;
         WAIT_SOF: s_ready = 1'b1;
         ACTIVE:   s_ready = x[0] ? slot_free : 1'b1;
         default:  s_ready = 1'b0;
      endcase
   end

   // Frame FSM, position counters, half-pixel store and status.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state          <= IDLE;
         width          <= '0;
         height         <= '0;
         x              <= '0;
         y              <= '0;
         half           <= 16'h0000;
         oneshot_done   <= 1'b0;
         sts_err        <= 1'b0;
         sts_frame_cnt  <= '0;
         irq_frame_done <= 1'b0;
      end else begin
         irq_frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (!cfg_enable) begin
                  oneshot_done <= 1'b0;
               end else if (!oneshot_done) begin
                  width  <= cfg_width_even;
                  height <= cfg_height;
                  if ((cfg_width_even < W_BITS'(2)) || (cfg_height == {H_BITS{1'b0}}))
                     sts_err <= 1'b1;
                  else
                     state <= WAIT_SOF;
               end
            end
            WAIT_SOF: begin
               if (!cfg_enable) begin
                  state <= IDLE;
               end else if (accept && s_axis_tuser) begin
                  half  <= pix_565;
                  x     <= W_BITS'(1);
                  y     <= '0;
                  state <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (sof_err) begin
                  // Stray SOF: drop the partial frame and restart on this beat.
                  sts_err <= 1'b1;
                  half    <= pix_565;
                  x       <= W_BITS'(1);
                  y       <= '0;
               end else if (accept) begin
                  if (s_axis_tlast != x_last)
                     sts_err <= 1'b1;
                  if (!x[0])
                     half <= pix_565;
                  if (x_last) begin
                     x <= '0;
                     if (y_last) begin
                        y              <= '0;
                        sts_frame_cnt  <= sts_frame_cnt + FCNT_BITS'(1);
                        irq_frame_done <= 1'b1;
                        if (cfg_enable && !cfg_oneshot) begin
                           state <= WAIT_SOF;
                        end else begin
                           state        <= IDLE;
                           oneshot_done <= cfg_oneshot;
                        end
                     end else begin
                        y <= y + H_BITS'(1);
                     end
                  end else begin
                     x <= x + W_BITS'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RGB565_ROUND_EN
   // Two-deep output path: formed word waits in the stage, then moves to the output slot.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         stg_data      <= 32'h0000_0000;
         stg_valid     <= 1'b0;
         stg_user      <= 1'b0;
         stg_last      <= 1'b0;
         m_axis_tdata  <= 32'h0000_0000;
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         if (word_form) begin
            stg_data  <= {pix_565, half};
            stg_valid <= 1'b1;
            stg_user  <= (x == W_BITS'(1)) && (y == {H_BITS{1'b0}});
            stg_last  <= x_last;
         end else if (stg_move) begin
            stg_valid <= 1'b0;
         end
         if (stg_move) begin
            m_axis_tdata  <= stg_data;
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= stg_user;
            m_axis_tlast  <= stg_last;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end
`else
   // Output slot: loaded when an odd pixel completes a word, held until accepted.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         m_axis_tdata  <= 32'h0000_0000;
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else if (word_form) begin
         m_axis_tdata  <= {pix_565, half};
         m_axis_tvalid <= 1'b1;
         m_axis_tuser  <= (x == W_BITS'(1)) && (y == {H_BITS{1'b0}});
         m_axis_tlast  <= x_last;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_rgb565_frame_sequencer.sv
// Randomised bench for rgb565_frame_sequencer against a pixel-index reference model.
module tb_rgb565_frame_sequencer;
   localparam int W_BITS = 11, H_BITS = 11, FCNT_BITS = 16;
`ifdef RGB565_ROUND_EN
   localparam int          LAT   = 2;
   localparam logic [15:0] EXP0F = 16'h1082;
`else
   localparam int          LAT   = 1;
   localparam logic [15:0] EXP0F = 16'h0861;
`endif

   logic ACLK = 1'b0, ARESETN = 1'b0;
   logic cfg_enable = 1'b0, cfg_oneshot = 1'b0;
   logic [W_BITS-1:0] cfg_width = '0;
   logic [H_BITS-1:0] cfg_height = '0;
   logic [23:0] s_axis_tdata = '0;
   logic s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready = 1'b1;
   logic sts_busy, sts_err, irq_frame_done;
   logic [FCNT_BITS-1:0] sts_frame_cnt;

   rgb565_frame_sequencer #(.W_BITS(W_BITS), .H_BITS(H_BITS), .FCNT_BITS(FCNT_BITS)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .sts_busy(sts_busy), .sts_err(sts_err), .sts_frame_cnt(sts_frame_cnt),
      .irq_frame_done(irq_frame_done));

   always #5 ACLK = ~ACLK;

   typedef struct packed {logic [23:0] data; logic user; logic last;} beat_t;
   typedef struct packed {logic [31:0] data; logic user; logic last;} word_t;

   beat_t beats[$];
   word_t exp_q[$];
   int    n_checks = 0, n_errors = 0;
   int    exp_frames, irq_seen, words_got, words_exp, cur_w, cur_h, k, rdy_mode, stall_cnt;
   bit    exp_err, in_frame, stall_arm, drop_seen;
   logic [23:0] prev_pix;
   logic [31:0] last_word;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref565(input logic [23:0] p);
      int r, g, b;
      r = p[23:16]; g = p[15:8]; b = p[7:0];
`ifdef RGB565_ROUND_EN
      r = (r + 4) / 8; if (r > 31) r = 31;
      g = (g + 2) / 4; if (g > 63) g = 63;
      b = (b + 4) / 8; if (b > 31) b = 31;
`else
      r = r / 8; g = g / 4; b = b / 8;
`endif
      return {r[4:0], g[5:0], b[4:0]};
   endfunction

   // Reference model: pixel index k within the frame decides everything.
   task automatic model_beat(input beat_t bt);
      word_t w;
      int    col;
      if (!in_frame) begin
         if (bt.user) begin in_frame = 1; prev_pix = bt.data; k = 1; end
         return;
      end
      if (bt.user) begin exp_err = 1; prev_pix = bt.data; k = 1; return; end
      col = k % cur_w;
      if (bt.last != (col == cur_w - 1)) exp_err = 1;
      if (k % 2 == 1) begin
         w.data = {ref565(bt.data), ref565(prev_pix)};
         w.user = (k == 1);
         w.last = (col == cur_w - 1);
         exp_q.push_back(w);
         words_exp++;
      end else begin
         prev_pix = bt.data;
      end
      k++;
      if (k == cur_w * cur_h) begin exp_frames++; in_frame = 0; end
   endtask

   task automatic add_frame(input int w, input int h, input bit fixed, input logic [23:0] val);
      beat_t b;
      for (int i = 0; i < w * h; i++) begin
         b.data = fixed ? val : 24'($urandom);
         b.user = (i == 0);
         b.last = ((i % w) == w - 1);
         beats.push_back(b);
      end
   endtask

   task automatic send_beat(input beat_t b);
      bit hs = 0;
      int t = 0;
      s_axis_tdata = b.data; s_axis_tuser = b.user; s_axis_tlast = b.last; s_axis_tvalid = 1'b1;
      do begin @(negedge ACLK); hs = s_axis_tready; t++; end while (!hs && t < 300);
      @(posedge ACLK); #1;
      s_axis_tvalid = 1'b0;
      check("beat_accept", hs, 1);
      if (hs) model_beat(b);
   endtask

   task automatic run_beats(input bit gaps);
      beat_t b;
      while (beats.size() > 0) begin
         b = beats.pop_front();
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
         send_beat(b);
      end
   endtask

   task automatic do_reset();
      ARESETN = 1'b0; cfg_enable = 1'b0; cfg_oneshot = 1'b0; s_axis_tvalid = 1'b0;
      rdy_mode = 0; stall_cnt = 0; stall_arm = 0; drop_seen = 0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_outputs", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, sts_busy, sts_err,
                            irq_frame_done, s_axis_tready}, 0);
      check("rst_data", {sts_frame_cnt, m_axis_tdata}, 0);
      beats.delete(); exp_q.delete();
      in_frame = 0; k = 0; exp_frames = 0; irq_seen = 0; exp_err = 0;
      words_got = 0; words_exp = 0;
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
   endtask

   task automatic configure(input int w, input int h, input bit oneshot);
      cfg_width = W_BITS'(w); cfg_height = H_BITS'(h); cfg_oneshot = oneshot; cfg_enable = 1'b1;
      cur_w = w & ~1; cur_h = h;
   endtask

   task automatic end_scenario(input string tag);
      int t = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && t < 500) begin @(negedge ACLK); t++; end
      repeat (2) @(negedge ACLK);
      check({tag, "_drain"}, exp_q.size(), 0);
      check({tag, "_words"}, words_got, words_exp);
      check({tag, "_frame_cnt"}, sts_frame_cnt, exp_frames);
      check({tag, "_irq_pulses"}, irq_seen, exp_frames);
      check({tag, "_err"}, sts_err, exp_err);
      @(posedge ACLK); #1;
   endtask

   // Output monitor and scoreboard, sampled mid-cycle.
   always @(negedge ACLK) begin
      word_t w;
      if (irq_frame_done) irq_seen++;
      if (stall_cnt > 0 && s_axis_tvalid && !s_axis_tready) drop_seen = 1;
      if (m_axis_tvalid && m_axis_tready) begin
         words_got++;
         last_word = m_axis_tdata;
         if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("word", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, {w.user, w.last, w.data});
         end
         if (stall_arm) begin stall_arm = 0; stall_cnt = 10; end
      end
   end

   // Downstream ready: always, random, or a forced stall window.
   always @(posedge ACLK) begin
      #1;
      if (stall_cnt > 0) begin m_axis_tready = 1'b0; stall_cnt--; end
      else m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   initial begin
      beat_t b;
      // 1: nominal 4x2 frame of a constant pixel
      do_reset(); configure(4, 2, 0);
      add_frame(4, 2, 1, 24'hFF8040); run_beats(0); end_scenario("t1");

      // 2: downstream stall after the first word
      do_reset(); configure(4, 2, 0); stall_arm = 1;
      add_frame(4, 2, 1, 24'hFF8040); run_beats(0); end_scenario("t2");
      check("t2_sready_drop", drop_seen, 1);

      // 3: non-SOF beats in WAIT_SOF are discarded
      do_reset(); configure(4, 2, 0);
      for (int i = 0; i < 3; i++) begin
         b.data = 24'($urandom); b.user = 1'b0; b.last = 1'($urandom_range(0, 1));
         beats.push_back(b);
      end
      add_frame(4, 2, 0, 24'h0); run_beats(1); end_scenario("t3");

      // 4: stray SOF on beat 5 restarts the frame
      do_reset(); configure(4, 2, 0);
      add_frame(4, 2, 0, 24'h0);
      repeat (3) void'(beats.pop_back());
      add_frame(4, 2, 0, 24'h0); run_beats(0); end_scenario("t4");

      // 5: one-shot processes exactly one frame
      do_reset(); configure(4, 2, 1);
      add_frame(4, 2, 0, 24'h0); run_beats(0); end_scenario("t5");
      check("t5_busy", sts_busy, 0);
      s_axis_tdata = 24'h123456; s_axis_tuser = 1'b1; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
      repeat (5) begin @(negedge ACLK); check("t5_no_accept", s_axis_tready, 0); end
      @(posedge ACLK); #1; s_axis_tvalid = 1'b0;

      // 6: conversion corner pixels and odd-pixel latency
      do_reset(); configure(2, 1, 0);
      b.data = 24'h0F0F0F; b.user = 1'b1; b.last = 1'b0; send_beat(b);
      b.data = 24'hFFFFFF; b.user = 1'b0; b.last = 1'b1; send_beat(b);
      @(negedge ACLK); check("t6_lat_n1", m_axis_tvalid, (LAT == 1));
      if (LAT == 2) begin @(negedge ACLK); check("t6_lat_n2", m_axis_tvalid, 1); end
      end_scenario("t6");
      check("t6_word", last_word, {16'hFFFF, EXP0F});

      // 7: random geometry, back-to-back frames, noise between frames, random backpressure
      for (int r = 0; r < 4; r++) begin
         int w, h;
         do_reset(); w = $urandom_range(2, 17); h = $urandom_range(1, 4);
         configure(w, h, 0); rdy_mode = 1;
         for (int f = 0; f < 3; f++) begin
            add_frame(cur_w, cur_h, 0, 24'h0);
            repeat ($urandom_range(0, 2)) begin
               b.data = 24'($urandom); b.user = 1'b0; b.last = 1'b0; beats.push_back(b);
            end
         end
         run_beats(1); end_scenario("t7");
      end

      // 8: cfg_enable dropped mid-frame lets the frame finish, then IDLE
      do_reset(); configure(4, 2, 0); add_frame(4, 2, 0, 24'h0);
      for (int i = 0; i < 3; i++) begin b = beats.pop_front(); send_beat(b); end
      cfg_enable = 1'b0; run_beats(0); end_scenario("t8");
      check("t8_busy", sts_busy, 0);

      // 9: degenerate geometry is rejected
      do_reset(); configure(1, 2, 0);
      repeat (3) @(negedge ACLK);
      check("t9_err_w", {sts_err, sts_busy}, 2'b10);
      do_reset(); configure(4, 0, 0);
      repeat (3) @(negedge ACLK);
      check("t9_err_h", {sts_err, sts_busy}, 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
